// File: rtl/reg_file_loader.sv
// reg_file_loader
//   Loads an 8 x 3-bit register file one entry at a time from a bouncing
//   pushbutton. Each debounced press writes the switch value into the next
//   free entry (0..7). Once all eight entries are written the block reports
//   full and ignores further presses until cleared or reset.
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   rst      in   asynchronous active-high reset
//   sw       in   [2:0] value written on a load
//   PB1      in   raw asynchronous load pushbutton, active-high
//   clr      in   synchronous clear of the register file and counters
//   rd_addr  in   [2:0] read address
//   rd_data  out  [2:0] combinational read of entry rd_addr
//   wr_count out  [3:0] number of entries written, 0..8
//   full     out  all eight entries written
//   done     out  one-cycle pulse when full first rises
//   led      out  [7:0] {full, wr_count, last written value}

module reg_file_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw,
  input  logic       PB1,
  input  logic       clr,
  input  logic [2:0] rd_addr,
  output logic [2:0] rd_data,
  output logic [3:0] wr_count,
  output logic       full,
  output logic       done,
  output logic [7:0] led
);

  // The debounce counter only has to reach DEBOUNCE_CYCLES-1: the level
  // flips on the cycle that would have been the DEBOUNCE_CYCLES-th mismatch.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic          deb_prev_q, deb_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    wr_count_q, wr_count_d;
  logic          full_q, full_d;
  logic          done_q, done_d;
  logic [2:0]    last_q, last_d;
  logic [2:0]    mem_q [8];
  logic [2:0]    mem_d [8];
  logic          load_pulse;

  // Synchroniser and debouncer. The counter runs only while the synchronised
  // level disagrees with the accepted level; any agreeing cycle zeroes it.
  always_comb begin
    sync1_d    = PB1;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    deb_prev_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Rising edge of the debounced level: one cycle wide however long PB1 is held.
  assign load_pulse = deb_q & ~deb_prev_q;

  // Fill control. Clear has priority over a coincident load; once FULL,
  // loads are ignored so wr_count cannot pass 8.
  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    full_d     = full_q;
    done_d     = 1'b0;
    last_d     = last_q;
    mem_d      = mem_q;
    if (clr) begin
      state_d    = FILL;
      wr_count_d = '0;
      full_d     = 1'b0;
      last_d     = '0;
      for (int i = 0; i < 8; i++) begin
        mem_d[i] = '0;
      end
    end else if (state_q == FILL && load_pulse) begin
      mem_d[wr_count_q[2:0]] = sw;
      wr_count_d             = wr_count_q + 4'd1;
      last_d                 = sw;
      if (wr_count_q == 4'd7) begin
        state_d = FULL;
        full_d  = 1'b1;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
      wr_count_q <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      last_q     <= '0;
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      wr_count_q <= wr_count_d;
      full_q     <= full_d;
      done_q     <= done_d;
      last_q     <= last_d;
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data  = mem_q[rd_addr];
  assign wr_count = wr_count_q;
  assign full     = full_q;
  assign done     = done_q;
  assign led      = {full_q, wr_count_q, last_q};

endmodule

// File: tb/tb_reg_file_loader.sv
// tb_reg_file_loader
//   Randomised bench for reg_file_loader. Presses are generated at the level
//   of whole button gestures (clean press, bounced press, bounce-only noise,
//   clear) and a register-file model predicts the contents, count, full flag,
//   number of done pulses and led pattern after each gesture.

module tb_reg_file_loader;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw;
  logic       PB1;
  logic       clr;
  logic [2:0] rd_addr;
  logic [2:0] rd_data;
  logic [3:0] wr_count;
  logic       full;
  logic       done;
  logic [7:0] led;

  int checks = 0;
  int failures = 0;

  int model_mem [8];
  int model_cnt;
  int model_last;
  int model_full;
  int exp_done;
  int done_seen = 0;
  bit led_known;
  int lat;

  reg_file_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .PB1      (PB1),
    .clr      (clr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_count (wr_count),
    .full     (full),
    .done     (done),
    .led      (led)
  );

  always #10 clk = ~clk;

  // Count every cycle on which done is high; compared against the number of
  // times the model reached eight entries.
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Reference model: entries fill in order, the eighth write sets full and
  // produces one done pulse, later writes are dropped.
  task automatic modelWrite(input int v);
    if (model_cnt < 8) begin
      model_mem[model_cnt] = v;
      model_cnt++;
      model_last = v;
      led_known = 1'b1;
      if (model_cnt == 8) begin
        model_full = 1;
        exp_done++;
      end
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 8; i++) model_mem[i] = 0;
    model_cnt  = 0;
    model_full = 0;
    model_last = 0;
  endtask

  // Called at a falling edge; drives PB1 and waits cyc falling edges.
  task automatic holdPb(input bit lvl, input int cyc);
    PB1 = lvl;
    repeat (cyc) @(negedge clk);
  endtask

  // kind: 0 clear, 1 bounce noise only, 2 bounced press, 3 clean press
  task automatic applyStimulus(input int kind, input int swv, input int nb);
    case (kind)
      0: begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        modelClear();
        led_known = 1'b0;
      end
      1: begin
        for (int i = 0; i < nb; i++) begin
          holdPb(1'b1, $urandom_range(1, DB - 1));
          holdPb(1'b0, $urandom_range(1, DB - 1));
        end
        holdPb(1'b0, DB + 4);
      end
      2: begin
        sw = 3'(swv);
        for (int i = 0; i < nb; i++) begin
          holdPb(1'b1, $urandom_range(1, DB - 1));
          holdPb(1'b0, $urandom_range(1, DB - 1));
        end
        holdPb(1'b1, DB + 8);
        holdPb(1'b0, DB + 8);
        modelWrite(swv);
      end
      default: begin
        sw = 3'(swv);
        holdPb(1'b1, DB + 8);
        holdPb(1'b0, DB + 8);
        modelWrite(swv);
      end
    endcase
  endtask

  // Called at a falling edge; reads every entry in a random rotation and
  // realigns to the next falling edge.
  task automatic checkAll(input string tag);
    int start;
    checkOutput($sformatf("%s.wr_count", tag), wr_count, model_cnt);
    checkOutput($sformatf("%s.full", tag), full, model_full);
    checkOutput($sformatf("%s.done_pulses", tag), done_seen, exp_done);
    if (led_known)
      checkOutput($sformatf("%s.led", tag), led,
                  model_full * 128 + model_cnt * 8 + model_last);
    start = $urandom_range(0, 7);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'((start + i) % 8);
      #1;
      checkOutput($sformatf("%s.entry%0d", tag, (start + i) % 8), rd_data,
                  model_mem[(start + i) % 8]);
    end
    @(negedge clk);
  endtask

  initial begin
    int seq [8] = '{3, 4, 7, 2, 3, 5, 0, 2};
    int v;
    int k;

    rst = 1'b1;
    PB1 = 1'b0;
    sw = '0;
    clr = 1'b0;
    rd_addr = '0;
    modelClear();
    exp_done = 0;
    led_known = 1'b1;
    repeat (2) @(negedge clk);
    checkAll("reset");
    rst = 1'b0;
    @(negedge clk);

    // First press also measures PB1-to-visible latency.
    sw = 3'(seq[0]);
    PB1 = 1'b1;
    lat = 0;
    while (wr_count == 4'd0 && lat < 4 * DB + 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency_in_range", int'(lat >= DB + 3 && lat <= DB + 5), 1);
    holdPb(1'b1, 4);
    holdPb(1'b0, DB + 8);
    modelWrite(seq[0]);
    for (int i = 1; i < 8; i++) applyStimulus(3, seq[i], 0);
    checkAll("fill8");
    checkOutput("fill8.led_pattern", led, 8'b1_1000_010);
    checkOutput("fill8.done_once", done_seen, 1);

    applyStimulus(3, 6, 0);
    checkAll("press_when_full");

    applyStimulus(0, 0, 0);
    applyStimulus(3, 1, 0);
    checkAll("clr_then_press");

    applyStimulus(0, 0, 0);
    applyStimulus(2, $urandom_range(0, 7), 5);
    checkAll("bounced_press");

    applyStimulus(1, 0, 4);
    checkAll("bounce_only");

    // Clear lands on the same edge as the load pulse.
    if (lat < 2) lat = 2;
    sw = 3'($urandom_range(0, 7));
    PB1 = 1'b1;
    repeat (lat - 1) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    modelClear();
    led_known = 1'b0;
    holdPb(1'b1, DB + 4);
    holdPb(1'b0, DB + 8);
    checkAll("clr_with_load");

    // Reset in the middle of debouncing a press after three writes.
    for (int i = 0; i < 3; i++) applyStimulus(3, $urandom_range(1, 7), 0);
    checkAll("pre_reset");
    v = $urandom_range(1, 7);
    sw = 3'(v);
    PB1 = 1'b1;
    repeat (DB) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    modelClear();
    led_known = 1'b1;
    checkOutput("async_rst.wr_count", wr_count, 0);
    checkOutput("async_rst.full", full, 0);
    checkOutput("async_rst.done", done, 0);
    checkOutput("async_rst.led", led, 0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      checkOutput($sformatf("async_rst.entry%0d", i), rd_data, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    holdPb(1'b1, DB + 8);
    holdPb(1'b0, DB + 8);
    modelWrite(v);
    checkAll("held_after_reset");

    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 9);
      v = $urandom_range(0, 7);
      if (k == 0) applyStimulus(0, 0, 0);
      else if (k == 1) applyStimulus(1, 0, $urandom_range(1, 5));
      else if (k <= 3) applyStimulus(2, v, $urandom_range(1, 5));
      else applyStimulus(3, v, 0);
      checkAll($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_loader.md
REG_FILE_LOADER -- requirements
Module: reg_file_loader

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronised cycles needed to accept a button level change.
REQ-002 The block SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port sw, input, 3: value to be written into the register file.
REQ-005 The block SHALL have port PB1, input, 1: raw, asynchronous, bouncing load pushbutton, active-high.
REQ-006 The block SHALL have port clr, input, 1: synchronous single-cycle clear request, active-high.
REQ-007 The block SHALL have port rd_addr, input, 3: read address for the downstream parity stage.
REQ-008 The block SHALL have port rd_data, output, 3: combinational read of entry rd_addr.
REQ-009 The block SHALL have port wr_count, output, 4: number of entries written, 0..8.
REQ-010 The block SHALL have port full, output, 1: high when all 8 entries are written.
REQ-011 The block SHALL have port done, output, 1: one-cycle pulse on the cycle full first rises.
REQ-012 The block SHALL have port led, output, 8: {full, wr_count[3:0], last written value[2:0]}.

Function
REQ-013 Storage SHALL be 8 entries x 3 bits, written in address order 0..7.
REQ-014 PB1 SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-015 Debounced level SHALL change only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle SHALL restart the count.
REQ-016 A load pulse SHALL be one cycle wide, on a 0->1 transition of the debounced level only; holding PB1 SHALL give exactly one pulse.
REQ-017 FSM states SHALL be FILL and FULL.
REQ-018 In FILL, a load pulse SHALL write sw into entry wr_count[2:0] and increment wr_count at the same clock edge.
REQ-019 sw SHALL be sampled on the clock edge that ends the load-pulse cycle.
REQ-020 The write making wr_count 8 SHALL move the FSM to FULL, set full, and pulse done for exactly the next cycle.
REQ-021 In FULL, load pulses SHALL be ignored: no write, wr_count held at 8, no done.
REQ-022 clr in either state SHALL zero all entries and wr_count, clear full and done, and go to FILL at the next edge.
REQ-023 clr together with a load pulse SHALL perform only the clear.
REQ-024 rd_data SHALL update in the same cycle as rd_addr and SHALL show a new write from the cycle after the write edge.
REQ-025 Latency from a clean PB1 rise to the written entry becoming visible SHALL be 2 + DEBOUNCE_CYCLES + 2 cycles, +/-1.
REQ-026 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no load pulse.
REQ-027 wr_count SHALL never exceed 8 and SHALL never wrap.

Reset
REQ-028 rst high SHALL, immediately and independent of clk, zero all 8 entries, wr_count, full, done, last-value register, synchroniser flops, debounced level and debounce counter, and set state FILL.
REQ-029 Reset SHALL override a write in progress; no partial write SHALL survive.
REQ-030 After rst falls, a PB1 already held high SHALL produce one load pulse once debounced.

Verification
REQ-031 Reset, then 8 clean presses with sw = 3,4,7,2,3,5,0,2 -> rd_data at addr 0..7 = 3,4,7,2,3,5,0,2; full=1; done high one cycle; led=8'b1_1000_010.
REQ-032 One press with 5 bounce pulses each < DEBOUNCE_CYCLES, then stable high -> exactly one write; wr_count=1.
REQ-033 9th press while FULL with sw=6 -> no entry changes; wr_count=8; done stays 0.
REQ-034 clr after full, then one press with sw=1 -> entry0=1; entries 1..7=0; wr_count=1; full=0.
REQ-035 rst asserted mid-debounce after 3 writes -> all outputs 0 at once; after release, held PB1 gives one write to entry 0.
REQ-036 clr and load pulse in the same cycle -> wr_count=0; no write.
